// File: rtl/el2_ifu_ifc_ctl_pkg.sv
// Shared types and defaults for the IFU fetch-control stage:
// FSM encoding, fetch-buffer depth, reset vector and the sequential-line helper.
package el2_ifu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      STALL = 2'b10,
      WFM   = 2'b11
   } ifc_state_e;

   localparam int          FB_DEPTH_DEFAULT  = 4;
   localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

   // Next 8-byte fetch line; wraps from 0xFFFF_FFF8 back to 0.
   function automatic logic [31:0] next_line(input logic [31:0] addr);
      return {addr[31:3] + 29'd1, 3'b000};
   endfunction

endpackage

// File: rtl/el2_ifu_ifc_ctl_if.sv
// Fetch-control bus: EXU/TLU flush, predictor, I-cache and aligner inputs,
// fetch address/request outputs. master = fetch control, slave = its environment.
interface el2_ifu_ifc_ctl_if;

   logic        io_exu_flush_final;
   logic [30:0] io_exu_flush_path_final;
   logic        io_dec_tlu_flush_noredir_wb;
   logic        io_ifu_bp_hit_taken_f;
   logic [30:0] io_ifu_bp_btb_target_f;
   logic        io_ic_hit_f;
   logic        io_ifu_ic_mb_empty;
   logic        io_ifu_fb_consume1;
   logic        io_ifu_fb_consume2;
   logic        io_dma_iccm_stall_any;
   logic [31:0] io_ifc_fetch_addr_bf;
   logic        io_ifc_fetch_req_bf;
   logic [31:0] io_ifc_fetch_addr_f;
   logic        io_ifc_fetch_req_f;
   logic        io_ifu_pmu_fetch_stall;

   modport master (
      input  io_exu_flush_final, io_exu_flush_path_final, io_dec_tlu_flush_noredir_wb,
             io_ifu_bp_hit_taken_f, io_ifu_bp_btb_target_f, io_ic_hit_f,
             io_ifu_ic_mb_empty, io_ifu_fb_consume1, io_ifu_fb_consume2,
             io_dma_iccm_stall_any,
      output io_ifc_fetch_addr_bf, io_ifc_fetch_req_bf, io_ifc_fetch_addr_f,
             io_ifc_fetch_req_f, io_ifu_pmu_fetch_stall
   );

   modport slave (
      output io_exu_flush_final, io_exu_flush_path_final, io_dec_tlu_flush_noredir_wb,
             io_ifu_bp_hit_taken_f, io_ifu_bp_btb_target_f, io_ic_hit_f,
             io_ifu_ic_mb_empty, io_ifu_fb_consume1, io_ifu_fb_consume2,
             io_dma_iccm_stall_any,
      input  io_ifc_fetch_addr_bf, io_ifc_fetch_req_bf, io_ifc_fetch_addr_f,
             io_ifc_fetch_req_f, io_ifu_pmu_fetch_stall
   );

endinterface

// File: rtl/el2_ifu_ifc_ctl.sv
// IFU fetch control: fetch-address register, flush/BTB/sequential next-address
// select, fetch-buffer credit counter and the IDLE/FETCH/STALL/WFM fetch FSM.
import el2_ifu_pkg::*;

module el2_ifu_ifc_ctl #(
   parameter int          FB_DEPTH  = FB_DEPTH_DEFAULT,
   parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
   input logic               clock,
   input logic               reset,
   el2_ifu_ifc_ctl_if.master ifc
);

   localparam int          CW         = $clog2(FB_DEPTH + 1);
   localparam logic [CW-1:0] FB_FULL  = CW'(FB_DEPTH);
   localparam logic [31:0] RESET_ADDR = {RESET_VEC[31:1], 1'b0};

   ifc_state_e    state, next_state;
   logic [31:0]   addr_f, addr_bf;
   logic          req_f, req_bf;
   logic [CW-1:0] fb_count, count_next;
   logic [CW+1:0] count_inc, count_dec;
   logic          fire_f, flush_go;

   assign fire_f   = req_f & ifc.io_ic_hit_f;
   assign flush_go = ifc.io_exu_flush_final & ~ifc.io_dec_tlu_flush_noredir_wb;

   always_comb begin
      addr_bf = addr_f;
      if (ifc.io_exu_flush_final)
         addr_bf = {ifc.io_exu_flush_path_final, 1'b0};
      else if (fire_f && ifc.io_ifu_bp_hit_taken_f)
         addr_bf = {ifc.io_ifu_bp_btb_target_f, 1'b0};
      else if (fire_f)
         addr_bf = next_line(addr_f);
   end

   // Credits are judged on the post-consume count so a full buffer that is
   // being drained in the same cycle keeps fetching without a bubble.
   always_comb begin
      count_inc  = (CW+2)'(fb_count) + (CW+2)'(fire_f);
      count_dec  = (CW+2)'(ifc.io_ifu_fb_consume1) + ((CW+2)'(ifc.io_ifu_fb_consume2) << 1);
      count_next = ifc.io_exu_flush_final ? '0 : CW'(count_inc - count_dec);
   end

   always_comb begin
      next_state = state;
      if (ifc.io_exu_flush_final) begin
         next_state = ifc.io_dec_tlu_flush_noredir_wb ? IDLE : FETCH;
      end else begin
         unique case (state)
            IDLE:  next_state = IDLE;
            FETCH: begin
               if (req_f && !ifc.io_ic_hit_f)
                  next_state = WFM;
               else if (count_next == FB_FULL || ifc.io_dma_iccm_stall_any)
                  next_state = STALL;
            end
            WFM:   if (ifc.io_ifu_ic_mb_empty) next_state = FETCH;
            STALL: if (count_next < FB_FULL && !ifc.io_dma_iccm_stall_any) next_state = FETCH;
            default: next_state = FETCH;
         endcase
      end
   end

   assign req_bf = flush_go |
                   (next_state == FETCH && count_next < FB_FULL && !ifc.io_dma_iccm_stall_any);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         addr_f   <= RESET_ADDR;
         req_f    <= 1'b0;
         fb_count <= '0;
      end else begin
         state    <= next_state;
         addr_f   <= addr_bf;
         req_f    <= req_bf;
         fb_count <= count_next;
      end
   end

   assign ifc.io_ifc_fetch_addr_bf   = addr_bf;
   assign ifc.io_ifc_fetch_req_bf    = req_bf;
   assign ifc.io_ifc_fetch_addr_f    = addr_f;
   assign ifc.io_ifc_fetch_req_f     = req_f;
   assign ifc.io_ifu_pmu_fetch_stall = ~req_bf & (state != IDLE);

   credit_bounds: assert property (@(posedge clock) disable iff (reset)
      ifc.io_exu_flush_final ||
      (count_inc >= count_dec && (count_inc - count_dec) <= (CW+2)'(FB_DEPTH)));

   consume_exclusive: assert property (@(posedge clock) disable iff (reset)
      !(ifc.io_ifu_fb_consume1 && ifc.io_ifu_fb_consume2));

endmodule

// File: tb/tb_el2_ifu_ifc_ctl.sv
// Bench for el2_ifu_ifc_ctl: directed scenarios against literal expectations,
// then a random run against a behavioural fetch model (credits + halt/miss flags).
module tb_el2_ifu_ifc_ctl;

   localparam int FB = 4;

   logic clock = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   el2_ifu_ifc_ctl_if bus();

   el2_ifu_ifc_ctl #(.FB_DEPTH(FB), .RESET_VEC(32'h8000_0000)) dut (
      .clock (clock),
      .reset (reset),
      .ifc   (bus.master)
   );

   // Reference model: registered view plus derived next-cycle values
   logic [31:0] m_addr_f, m_addr_bf;
   logic        m_req_f, m_req_bf, m_pmu;
   int          m_credits, m_used;
   bit          m_halted, m_waiting, m_halted_n, m_waiting_n;

   task automatic idle_inputs();
      bus.io_exu_flush_final          = 1'b0;
      bus.io_exu_flush_path_final     = '0;
      bus.io_dec_tlu_flush_noredir_wb = 1'b0;
      bus.io_ifu_bp_hit_taken_f       = 1'b0;
      bus.io_ifu_bp_btb_target_f      = '0;
      bus.io_ic_hit_f                 = 1'b0;
      bus.io_ifu_ic_mb_empty          = 1'b0;
      bus.io_ifu_fb_consume1          = 1'b0;
      bus.io_ifu_fb_consume2          = 1'b0;
      bus.io_dma_iccm_stall_any       = 1'b0;
   endtask

   task automatic model_eval();
      bit fl, nr, fire;
      fl   = bus.io_exu_flush_final;
      nr   = bus.io_dec_tlu_flush_noredir_wb;
      fire = m_req_f && bus.io_ic_hit_f;
      m_used = fl ? 0 : m_credits + int'(fire) - int'(bus.io_ifu_fb_consume1)
                        - 2 * int'(bus.io_ifu_fb_consume2);
      if (fl) begin
         m_halted_n  = nr;
         m_waiting_n = 1'b0;
      end else begin
         m_halted_n = m_halted;
         if (m_waiting) m_waiting_n = !bus.io_ifu_ic_mb_empty;
         else           m_waiting_n = !m_halted && m_req_f && !bus.io_ic_hit_f;
      end
      m_req_bf = (fl && !nr) ||
                 (!m_halted_n && !m_waiting_n && m_used < FB && !bus.io_dma_iccm_stall_any);
      if (fl)                                  m_addr_bf = {bus.io_exu_flush_path_final, 1'b0};
      else if (fire && bus.io_ifu_bp_hit_taken_f) m_addr_bf = {bus.io_ifu_bp_btb_target_f, 1'b0};
      else if (fire)                           m_addr_bf = (m_addr_f & 32'hFFFF_FFF8) + 32'd8;
      else                                     m_addr_bf = m_addr_f;
      m_pmu = !m_req_bf && !m_halted;
   endtask

   task automatic cycle();
      model_eval();
      @(posedge clock);
      #1;
      m_addr_f  = m_addr_bf;
      m_req_f   = m_req_bf;
      m_credits = m_used;
      m_halted  = m_halted_n;
      m_waiting = m_waiting_n;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clock);
      #1;
      m_addr_f = 32'h8000_0000; m_req_f = 1'b0; m_credits = 0;
      m_halted = 1'b0; m_waiting = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'h8000_0000) begin errors++; $display("[TB] FAIL rst_addr_f: got %h want 80000000", bus.io_ifc_fetch_addr_f); end
      checks++; if (bus.io_ifc_fetch_req_f !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_f: got %b want 0", bus.io_ifc_fetch_req_f); end
      do_reset();
      #1;
      checks++; if (bus.io_ifc_fetch_addr_bf !== 32'h8000_0000) begin errors++; $display("[TB] FAIL rst_addr_bf: got %h want 80000000", bus.io_ifc_fetch_addr_bf); end
      checks++; if (bus.io_ifc_fetch_req_bf !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_bf: got %b want 1", bus.io_ifc_fetch_req_bf); end
      checks++; if (bus.io_ifu_pmu_fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_pmu: got %b want 0", bus.io_ifu_pmu_fetch_stall); end
      cycle();
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'h8000_0000) begin errors++; $display("[TB] FAIL rst_c2_addr_f: got %h want 80000000", bus.io_ifc_fetch_addr_f); end
      checks++; if (bus.io_ifc_fetch_req_f !== 1'b1) begin errors++; $display("[TB] FAIL rst_c2_req_f: got %b want 1", bus.io_ifc_fetch_req_f); end
   endtask

   task automatic test_sequential();
      do_reset();
      cycle();
      for (int k = 0; k < 6; k++) begin
         bus.io_ic_hit_f = 1'b1; bus.io_ifu_fb_consume1 = 1'b1;
         #1;
         checks++; if (bus.io_ifc_fetch_addr_f !== 32'h8000_0000 + 32'(8 * k)) begin errors++; $display("[TB] FAIL seq_addr_f[%0d]: got %h want %h", k, bus.io_ifc_fetch_addr_f, 32'h8000_0000 + 32'(8 * k)); end
         checks++; if (bus.io_ifc_fetch_addr_bf !== 32'h8000_0008 + 32'(8 * k)) begin errors++; $display("[TB] FAIL seq_addr_bf[%0d]: got %h want %h", k, bus.io_ifc_fetch_addr_bf, 32'h8000_0008 + 32'(8 * k)); end
         checks++; if (bus.io_ifc_fetch_req_f !== 1'b1 || bus.io_ifu_pmu_fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL seq_req_pmu[%0d]: got %b/%b want 1/0", k, bus.io_ifc_fetch_req_f, bus.io_ifu_pmu_fetch_stall); end
         cycle();
      end
      idle_inputs();
   endtask

   task automatic test_taken();
      do_reset();
      cycle();
      bus.io_ic_hit_f = 1'b1; bus.io_ifu_fb_consume1 = 1'b1;
      cycle();
      bus.io_ifu_bp_hit_taken_f = 1'b1; bus.io_ifu_bp_btb_target_f = 31'h2000_0008;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_bf !== 32'h4000_0010) begin errors++; $display("[TB] FAIL taken_addr_bf: got %h want 40000010", bus.io_ifc_fetch_addr_bf); end
      cycle();
      bus.io_ifu_bp_hit_taken_f = 1'b0;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'h4000_0010 || bus.io_ifc_fetch_req_f !== 1'b1) begin errors++; $display("[TB] FAIL taken_addr_f: got %h/%b want 40000010/1", bus.io_ifc_fetch_addr_f, bus.io_ifc_fetch_req_f); end
      checks++; if (bus.io_ifc_fetch_addr_bf !== 32'h4000_0018) begin errors++; $display("[TB] FAIL taken_next: got %h want 40000018", bus.io_ifc_fetch_addr_bf); end
      bus.io_ic_hit_f = 1'b0; bus.io_ifu_fb_consume1 = 1'b0;
      bus.io_ifu_bp_hit_taken_f = 1'b1; bus.io_ifu_bp_btb_target_f = 31'h0000_1000;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_bf !== 32'h4000_0010) begin errors++; $display("[TB] FAIL taken_nohit: got %h want 40000010", bus.io_ifc_fetch_addr_bf); end
      idle_inputs();
   endtask

   task automatic test_miss();
      do_reset();
      cycle();
      repeat (2) begin
         bus.io_ic_hit_f = 1'b1; bus.io_ifu_fb_consume1 = 1'b1;
         cycle();
      end
      bus.io_ic_hit_f = 1'b0; bus.io_ifu_fb_consume1 = 1'b0;
      #1;
      checks++; if (bus.io_ifc_fetch_req_bf !== 1'b0 || bus.io_ifu_pmu_fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL miss_seen: req_bf/pmu got %b/%b want 0/1", bus.io_ifc_fetch_req_bf, bus.io_ifu_pmu_fetch_stall); end
      cycle();
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (bus.io_ifc_fetch_req_f !== 1'b0 || bus.io_ifu_pmu_fetch_stall !== 1'b1 || bus.io_ifc_fetch_addr_f !== 32'h8000_0010) begin errors++; $display("[TB] FAIL miss_wait[%0d]: req_f/pmu/addr got %b/%b/%h want 0/1/80000010", k, bus.io_ifc_fetch_req_f, bus.io_ifu_pmu_fetch_stall, bus.io_ifc_fetch_addr_f); end
         cycle();
      end
      bus.io_ifu_ic_mb_empty = 1'b1;
      #1;
      checks++; if (bus.io_ifc_fetch_req_bf !== 1'b1 || bus.io_ifu_pmu_fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL miss_done: req_bf/pmu got %b/%b want 1/0", bus.io_ifc_fetch_req_bf, bus.io_ifu_pmu_fetch_stall); end
      cycle();
      bus.io_ifu_ic_mb_empty = 1'b0; bus.io_ic_hit_f = 1'b1; bus.io_ifu_fb_consume1 = 1'b1;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'h8000_0010 || bus.io_ifc_fetch_req_f !== 1'b1) begin errors++; $display("[TB] FAIL miss_refetch: got %h/%b want 80000010/1", bus.io_ifc_fetch_addr_f, bus.io_ifc_fetch_req_f); end
      cycle();
      bus.io_ic_hit_f = 1'b0; bus.io_ifu_fb_consume1 = 1'b0;
      cycle();
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'h8000_0000 || bus.io_ifc_fetch_req_f !== 1'b0) begin errors++; $display("[TB] FAIL miss_async_rst: got %h/%b want 80000000/0", bus.io_ifc_fetch_addr_f, bus.io_ifc_fetch_req_f); end
      do_reset();
      #1;
      checks++; if (bus.io_ifc_fetch_req_bf !== 1'b1) begin errors++; $display("[TB] FAIL miss_rst_req_bf: got %b want 1", bus.io_ifc_fetch_req_bf); end
   endtask

   task automatic test_full();
      do_reset();
      bus.io_ic_hit_f = 1'b1;
      cycle();
      for (int k = 1; k <= 4; k++) begin
         #1;
         checks++; if (bus.io_ifc_fetch_req_bf !== (k < 4)) begin errors++; $display("[TB] FAIL full_fill[%0d]: req_bf got %b want %b", k, bus.io_ifc_fetch_req_bf, (k < 4)); end
         cycle();
      end
      #1;
      checks++; if (bus.io_ifc_fetch_req_bf !== 1'b0 || bus.io_ifc_fetch_req_f !== 1'b0 || bus.io_ifu_pmu_fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL full_stall: req_bf/req_f/pmu got %b/%b/%b want 0/0/1", bus.io_ifc_fetch_req_bf, bus.io_ifc_fetch_req_f, bus.io_ifu_pmu_fetch_stall); end
      bus.io_ifu_fb_consume2 = 1'b1;
      #1;
      checks++; if (bus.io_ifc_fetch_req_bf !== 1'b1 || bus.io_ifu_pmu_fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL full_consume2: req_bf/pmu got %b/%b want 1/0", bus.io_ifc_fetch_req_bf, bus.io_ifu_pmu_fetch_stall); end
      cycle();
      bus.io_ifu_fb_consume2 = 1'b0;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'h8000_0020 || bus.io_ifc_fetch_req_f !== 1'b1) begin errors++; $display("[TB] FAIL full_resume: got %h/%b want 80000020/1", bus.io_ifc_fetch_addr_f, bus.io_ifc_fetch_req_f); end
      cycle();
      bus.io_ifu_fb_consume1 = 1'b1;
      #1;
      checks++; if (bus.io_ifc_fetch_req_bf !== 1'b1 || bus.io_ifu_pmu_fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL full_with_consume: req_bf/pmu got %b/%b want 1/0", bus.io_ifc_fetch_req_bf, bus.io_ifu_pmu_fetch_stall); end
      idle_inputs();
   endtask

   task automatic fill_three_then_flush(input bit noredir);
      do_reset();
      bus.io_ic_hit_f = 1'b1;
      repeat (4) cycle();
      bus.io_exu_flush_final = 1'b1; bus.io_exu_flush_path_final = 31'h1000_0000;
      bus.io_dec_tlu_flush_noredir_wb = noredir;
      bus.io_ifu_bp_hit_taken_f = 1'b1; bus.io_ifu_bp_btb_target_f = 31'h0123_4567;
   endtask

   task automatic test_back_to_back();
      fill_three_then_flush(1'b0);
      #1;
      checks++; if (bus.io_ifc_fetch_addr_bf !== 32'h2000_0000 || bus.io_ifc_fetch_req_bf !== 1'b1) begin errors++; $display("[TB] FAIL flush_bf: got %h/%b want 20000000/1", bus.io_ifc_fetch_addr_bf, bus.io_ifc_fetch_req_bf); end
      cycle();
      idle_inputs(); bus.io_ic_hit_f = 1'b1;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'h2000_0000 || bus.io_ifc_fetch_req_f !== 1'b1) begin errors++; $display("[TB] FAIL flush_f: got %h/%b want 20000000/1", bus.io_ifc_fetch_addr_f, bus.io_ifc_fetch_req_f); end
      for (int k = 1; k <= 4; k++) begin
         #1;
         checks++; if (bus.io_ifc_fetch_req_bf !== (k < 4)) begin errors++; $display("[TB] FAIL flush_credits[%0d]: req_bf got %b want %b", k, bus.io_ifc_fetch_req_bf, (k < 4)); end
         cycle();
      end
      fill_three_then_flush(1'b1);
      #1;
      checks++; if (bus.io_ifc_fetch_req_bf !== 1'b0) begin errors++; $display("[TB] FAIL noredir_bf: req_bf got %b want 0", bus.io_ifc_fetch_req_bf); end
      cycle();
      idle_inputs(); bus.io_ic_hit_f = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.io_ifc_fetch_req_f !== 1'b0 || bus.io_ifc_fetch_req_bf !== 1'b0 || bus.io_ifu_pmu_fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL noredir_idle[%0d]: req_f/req_bf/pmu got %b/%b/%b want 0/0/0", k, bus.io_ifc_fetch_req_f, bus.io_ifc_fetch_req_bf, bus.io_ifu_pmu_fetch_stall); end
         cycle();
      end
      bus.io_exu_flush_final = 1'b1; bus.io_exu_flush_path_final = 31'h1800_0000;
      cycle();
      idle_inputs();
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'h3000_0000 || bus.io_ifc_fetch_req_f !== 1'b1) begin errors++; $display("[TB] FAIL noredir_wake: got %h/%b want 30000000/1", bus.io_ifc_fetch_addr_f, bus.io_ifc_fetch_req_f); end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.io_exu_flush_final = 1'b1; bus.io_exu_flush_path_final = 31'h7FFF_FFFC;
      cycle();
      idle_inputs(); bus.io_ic_hit_f = 1'b1;
      #1;
      checks++; if (bus.io_ifc_fetch_addr_f !== 32'hFFFF_FFF8 || bus.io_ifc_fetch_addr_bf !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wrap: addr_f/addr_bf got %h/%h want fffffff8/00000000", bus.io_ifc_fetch_addr_f, bus.io_ifc_fetch_addr_bf); end
      idle_inputs();
   endtask

   task automatic test_random();
      int avail, take;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         bus.io_exu_flush_final          = ($urandom_range(0, 99) < 4);
         bus.io_dec_tlu_flush_noredir_wb = ($urandom_range(0, 2) == 0);
         bus.io_exu_flush_path_final     = ($urandom_range(0, 3) == 0) ? 31'h7FFF_FFFC : 31'($urandom);
         bus.io_ifu_bp_hit_taken_f       = ($urandom_range(0, 3) == 0);
         bus.io_ifu_bp_btb_target_f      = 31'($urandom);
         bus.io_ic_hit_f                 = ($urandom_range(0, 4) != 0);
         bus.io_ifu_ic_mb_empty          = ($urandom_range(0, 2) == 0);
         bus.io_dma_iccm_stall_any       = ($urandom_range(0, 9) == 0);
         avail = m_credits + int'(m_req_f && bus.io_ic_hit_f);
         take  = $urandom_range(0, 2);
         if (take > avail) take = avail;
         bus.io_ifu_fb_consume1 = (take == 1);
         bus.io_ifu_fb_consume2 = (take == 2);
         #1;
         model_eval();
         checks++; if (bus.io_ifc_fetch_addr_f !== m_addr_f) begin errors++; $display("[TB] FAIL rnd_addr_f[%0d]: got %h want %h", i, bus.io_ifc_fetch_addr_f, m_addr_f); end
         checks++; if (bus.io_ifc_fetch_req_f !== m_req_f) begin errors++; $display("[TB] FAIL rnd_req_f[%0d]: got %b want %b", i, bus.io_ifc_fetch_req_f, m_req_f); end
         checks++; if (bus.io_ifc_fetch_addr_bf !== m_addr_bf) begin errors++; $display("[TB] FAIL rnd_addr_bf[%0d]: got %h want %h", i, bus.io_ifc_fetch_addr_bf, m_addr_bf); end
         checks++; if (bus.io_ifc_fetch_req_bf !== m_req_bf) begin errors++; $display("[TB] FAIL rnd_req_bf[%0d]: got %b want %b", i, bus.io_ifc_fetch_req_bf, m_req_bf); end
         checks++; if (bus.io_ifu_pmu_fetch_stall !== m_pmu) begin errors++; $display("[TB] FAIL rnd_pmu[%0d]: got %b want %b", i, bus.io_ifu_pmu_fetch_stall, m_pmu); end
         cycle();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      #12;
      test_reset();
      test_sequential();
      test_taken();
      test_miss();
      test_full();
      test_back_to_back();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/el2_ifu_ifc_ctl.md
# el2_ifu_ifc_ctl

Fetch-control stage of the EL2 IFU. Holds the fetch-address register and a four-state fetch FSM, and picks the next fetch address from three sources in priority order: EXU flush, taken BTB prediction, sequential. It drives `ifc_fetch_addr_f` and `ifc_fetch_req_f` into the branch predictor and I-cache, and consumes the predictor's `hit_taken`/`btb_target` in the same F cycle. It tracks fetch-buffer credits so that fetch never overruns the aligner.

## Interface
- `FB_DEPTH`, default 4: number of fetch-buffer entries (credits).
- `RESET_VEC`, default 32'h8000_0000: first fetch address after reset; bit 0 ignored.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `io_exu_flush_final`  in  1  redirect request.
- `io_exu_flush_path_final`  in  31  redirect target [31:1].
- `io_dec_tlu_flush_noredir_wb`  in  1  flush-and-halt; only meaningful together with `flush_final`.
- `io_ifu_bp_hit_taken_f`  in  1  predictor says the current F fetch is taken.
- `io_ifu_bp_btb_target_f`  in  31  predicted target [31:1].
- `io_ic_hit_f`  in  1  I-cache hit for the current F fetch.
- `io_ifu_ic_mb_empty`  in  1  miss buffer idle; the miss is serviced.
- `io_ifu_fb_consume1`  in  1  aligner frees one entry.
- `io_ifu_fb_consume2`  in  1  aligner frees two entries; mutually exclusive with `consume1`.
- `io_dma_iccm_stall_any`  in  1  DMA owns the ICCM; no new fetch.
- `io_ifc_fetch_addr_bf`  out  32  next fetch address, combinational; bit0 = 0.
- `io_ifc_fetch_req_bf`  out  1  next-cycle fetch request, combinational.
- `io_ifc_fetch_addr_f`  out  32  registered fetch address; bit0 = 0.
- `io_ifc_fetch_req_f`  out  1  registered fetch request.
- `io_ifu_pmu_fetch_stall`  out  1  fetch stalled while not idle.

## Operation
Qualifiers:
- `fire_f` = `req_f & ic_hit_f`.
- `flush_go` = `flush_final & ~noredir`.

Next-address priority for `addr_bf`:
1. `flush_final` → `path_final`.
2. `fire_f & hit_taken_f` → `btb_target_f`.
3. `fire_f` → `{addr_f[31:3]+1, 3'b0}`, the next 8-byte line. It wraps from 0xFFFF_FFF8 to 0.
4. Otherwise → `addr_f`, i.e. hold or replay.

`addr_f` loads `addr_bf` every cycle.

Fetch-buffer credits:
- `fb_count` is 0..FB_DEPTH.
- `count_next` = `fb_count + fire_f − consume1 − 2·consume2`.
- Any `flush_final` forces `count_next` = 0.
- Underflow or overflow is an assertion failure.

FSM, with `state` reset to FETCH:
- **Any state:** `flush_final & noredir` → IDLE; `flush_go` → FETCH. Flush has top priority.
- **IDLE:** hold until `flush_go`.
- **FETCH:**
  - `req_f & ~ic_hit_f` → WFM.
  - Else `count_next == FB_DEPTH` or `dma_stall` → STALL.
- **WFM:** `mb_empty` → FETCH. The same `addr_f` is refetched.
- **STALL:** `count_next < FB_DEPTH & ~dma_stall` → FETCH.

Request and stall outputs:
- `req_bf` = `flush_go | (next_state == FETCH & count_next < FB_DEPTH & ~dma_stall)`.
- `req_f` registers `req_bf`.
- `pmu_fetch_stall` = `~req_bf & state != IDLE`.

## Timing
- **Reset (asynchronous):**
  - `state` = FETCH, `fb_count` = 0.
  - `addr_f` = RESET_VEC with bit0 = 0; `req_f` = 0.
  - First cycle after release: `addr_bf` = RESET_VEC, `req_bf` = 1.
  - Reset asserted mid-miss or mid-stall aborts everything; no state is retained.
- **Flush:** a flush in cycle N gives `addr_bf` = path in N, and `addr_f` = path with `req_f` = 1 in N+1. This holds regardless of FB fullness, since the flush clears the buffer.
- **Taken prediction:** in cycle N it redirects `addr_f` in N+1. No bubble.
- **Miss:** `req_f` drops the cycle after the miss is seen. Refetch `req_f` = 1 comes one cycle after `mb_empty`.
- **Prediction without hit:** a prediction with `ic_hit_f` = 0 is ignored.
- **Full buffer with consume:** a full buffer with a simultaneous `consume` does not stall, because `count_next` is used.

## Structure
- Shared package `el2_ifu_pkg`:
  - FSM state enum: IDLE = 2'b00, FETCH = 2'b01, STALL = 2'b10, WFM = 2'b11.
  - `FB_DEPTH` and `RESET_VEC` defaults.
- The design is flat; no sub-module is warranted, as the credit counter is about 15 lines.

## Test plan
- **Reset:** release reset → cycle 1 `addr_bf` = 0x8000_0000, `req_bf` = 1; cycle 2 `addr_f` = 0x8000_0000, `req_f` = 1.
- **Sequential fetch:** steady `ic_hit` from 0x8000_0000, `consume1` every cycle → `addr_f` = 0x8000_0008, 0x8000_0010, ...; no stall.
- **Taken prediction:** `hit_taken` with `btb_target` = 0x4000_0010>>1 at `addr_f` = 0x8000_0008 → next `addr_f` = 0x4000_0010.
- **Miss:**
  - Miss at 0x8000_0010 → WFM, `req_f` = 0, `pmu_fetch_stall` = 1.
  - `mb_empty` after 5 cycles → `addr_f` = 0x8000_0010, `req_f` = 1.
- **Full buffer:**
  - 4 hits with no consume → STALL, `req_bf` = 0.
  - `consume2` → FETCH the same cycle, `req_bf` = 1.
- **Simultaneous events:**
  - `flush_final` with path 0x2000_0000 at the same time as `hit_taken` and a full buffer → `addr_f` = 0x2000_0000, `fb_count` = 0.
  - Same flush with `noredir` → IDLE, `req_f` = 0 until the next flush.
